// File: rtl/mem_responder_pkg.sv
// Purpose : shared types for the memory responder (FSM states, op codes, widths).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package mem_responder_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;   // holds WAIT_STATES in 0..15

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    MEM_OP_READ  = 1'b0,
    MEM_OP_WRITE = 1'b1
  } mem_op_t;

endpackage

// File: rtl/mem_responder_if.sv
// Purpose : request/response bundle between the datapath (master) and the memory target (slave).
// Latency : n/a (wiring only).
// Backpressure: level requests held by the master until mem_done; mem_busy shows an access in flight.
//  mem_addr/mem_wdata/mem_read/mem_write : master -> slave
//  mem_rdata/mem_done/mem_busy/mem_err   : slave -> master
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic              mem_busy;
  logic              mem_err;

  modport master (
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata, mem_done, mem_busy, mem_err
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata, mem_done, mem_busy, mem_err
  );
endinterface

// File: rtl/mem_responder_ram_array.sv
// Purpose : single-port synchronous RAM, DEPTH x 32.
// Latency : 1 cycle read (rdata registered), write on the clock edge with we=1.
// Backpressure: none; accepts an access every cycle.
//  clock, we, addr[ADDR_W], wdata[32] in; rdata[32] out. No reset so it maps to block RAM.
module ram_array #(
  parameter int    ADDR_W    = 9,
  parameter int    DEPTH     = 512,
  parameter string INIT_FILE = ""
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Purpose : word-addressed memory target for the CPU datapath with programmable wait states.
// Latency : mem_done pulses for one cycle after edge E+WAIT_STATES+1 (E = accepting edge).
// Backpressure: requests sampled only in IDLE; changes while busy/done are ignored.
//  clock, clear (async active-low) : plain ports
//  bus (slave modport)             : mem_addr/mem_wdata/mem_read/mem_write in,
//                                    mem_rdata/mem_done/mem_busy/mem_err out (all registered)
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int    ADDR_W      = 9,
  parameter int    DEPTH       = 512,
  parameter int    WAIT_STATES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic            clock,
  input  logic            clear,
  mem_responder_if.slave  bus
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  mem_op_t            op_q;
  logic               err_q;

  logic [DATA_W-1:0]  rdata_q;
  logic               done_q;
  logic               busy_q;
  logic               merr_q;

  logic               req;
  logic               accept_err;
  logic               access_now;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_addr;
  logic [DATA_W-1:0]  ram_rdata;

  assign req = bus.mem_read | bus.mem_write;

  // DEPTH <= 2**ADDR_W, so a full-width compare also catches any set bit above ADDR_W-1.
  assign accept_err = (bus.mem_read & bus.mem_write) | (bus.mem_addr >= 32'(DEPTH));

  assign access_now = (state == ACCESS) && (cnt == '0);
  assign ram_we     = access_now && (op_q == MEM_OP_WRITE) && !err_q;

  // In IDLE the RAM looks at the live address so that with zero wait states the
  // read word is already registered by the time the completing edge arrives.
  assign ram_addr = (state == IDLE) ? bus.mem_addr[ADDR_W-1:0] : addr_q;

  ram_array #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= MEM_OP_READ;
      err_q   <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= bus.mem_addr[ADDR_W-1:0];
            wdata_q <= bus.mem_wdata;
            op_q    <= bus.mem_write ? MEM_OP_WRITE : MEM_OP_READ;
            err_q   <= accept_err;
            cnt     <= CNT_W'(WAIT_STATES);
            busy_q  <= 1'b1;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            done_q <= 1'b1;
            merr_q <= err_q;
            // Only a clean read updates rdata; writes and errors leave it alone.
            if (!err_q && (op_q == MEM_OP_READ)) begin
              rdata_q <= ram_rdata;
            end
            state <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          merr_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_done  = done_q;
  assign bus.mem_busy  = busy_q;
  assign bus.mem_err   = merr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Purpose : self-checking bench for mem_responder (table vectors, corner sequences, random vs model).
// Latency : expects done WAIT_STATES+1 edges after acceptance.
// Backpressure: bench holds requests until done, then drops them.
module tb_mem_responder;

  localparam int W     = 2;
  localparam int DEPTH = 512;

  logic clock;
  logic clear;

  mem_responder_if bus();
  mem_responder_if bus0();
  mem_responder_if bus15();

  mem_responder #(.ADDR_W(9), .DEPTH(DEPTH), .WAIT_STATES(W), .INIT_FILE("")) dut (
    .clock (clock), .clear (clear), .bus (bus)
  );
  mem_responder #(.ADDR_W(9), .DEPTH(DEPTH), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
    .clock (clock), .clear (clear), .bus (bus0)
  );
  mem_responder #(.ADDR_W(9), .DEPTH(DEPTH), .WAIT_STATES(15), .INIT_FILE("")) dut15 (
    .clock (clock), .clear (clear), .bus (bus15)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One request held from before edge E until done; optional perturbation right after E.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input bit perturb, output int lat, output logic e, output logic [31:0] rdv,
                        output logic bsy_done, output logic bsy_after);
    @(negedge clock);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    lat = -1; e = 1'bx; rdv = 'x; bsy_done = 1'bx;
    for (int j = 0; j < 40; j++) begin
      @(negedge clock);
      if (perturb && j == 0) begin
        bus.mem_addr  = 32'd7;
        bus.mem_write = 1'b1;
        bus.mem_wdata = 32'h0BAD_0BAD;
      end
      if (bus.mem_done) begin
        lat = j; e = bus.mem_err; rdv = bus.mem_rdata; bsy_done = bus.mem_busy;
        break;
      end
    end
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    @(negedge clock);
    bsy_after = bus.mem_busy;
  endtask

  task automatic run_chk(input string nm, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input bit perturb,
                         input logic exp_err, input logic [31:0] exp_rdata);
    int lat; logic e; logic [31:0] rdv; logic bd, ba;
    do_req(rd, wr, a, d, perturb, lat, e, rdv, bd, ba);
    chk({nm, "_lat"}, 32'(lat), 32'(W + 1));
    chk({nm, "_err"}, {31'd0, e}, {31'd0, exp_err});
    chk({nm, "_rdata"}, rdv, exp_rdata);
    chk({nm, "_busy_at_done"}, {31'd0, bd}, 32'd1);
    chk({nm, "_busy_after"}, {31'd0, ba}, 32'd0);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[12];

  logic [31:0] ref_mem [int];
  logic [31:0] ref_rdata;

  initial begin
    int f0, s0, f15, s15, ndone;
    // rd, wr, addr, wdata, exp_err, exp_rdata (rdata only moves on clean reads)
    tbl[0]  = '{1'b0, 1'b1, 32'd5,          32'h1234_5678, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b1, 1'b0, 32'd5,          32'h0,         1'b0, 32'h1234_5678};
    tbl[2]  = '{1'b1, 1'b1, 32'd3,          32'hFFFF_FFFF, 1'b1, 32'h1234_5678};
    tbl[3]  = '{1'b1, 1'b0, 32'h200,        32'h0,         1'b1, 32'h1234_5678};
    tbl[4]  = '{1'b0, 1'b1, 32'd7,          32'h7777_7777, 1'b0, 32'h1234_5678};
    tbl[5]  = '{1'b0, 1'b1, 32'h1FF,        32'hA5A5_A5A5, 1'b0, 32'h1234_5678};
    tbl[6]  = '{1'b1, 1'b0, 32'h1FF,        32'h0,         1'b0, 32'hA5A5_A5A5};
    tbl[7]  = '{1'b0, 1'b1, 32'h8000_0005,  32'hDEAD_DEAD, 1'b1, 32'hA5A5_A5A5};
    tbl[8]  = '{1'b1, 1'b0, 32'd5,          32'h0,         1'b0, 32'h1234_5678};
    tbl[9]  = '{1'b0, 1'b1, 32'd9,          32'h0000_0011, 1'b0, 32'h1234_5678};
    tbl[10] = '{1'b1, 1'b0, 32'd9,          32'h0,         1'b0, 32'h0000_0011};
    tbl[11] = '{1'b1, 1'b0, 32'd7,          32'h0,         1'b0, 32'h7777_7777};

    clear = 1'b0;
    bus.mem_read = 0;   bus.mem_write = 0;   bus.mem_addr = 0;   bus.mem_wdata = 0;
    bus0.mem_read = 0;  bus0.mem_write = 0;  bus0.mem_addr = 0;  bus0.mem_wdata = 0;
    bus15.mem_read = 0; bus15.mem_write = 0; bus15.mem_addr = 0; bus15.mem_wdata = 0;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_rdata", bus.mem_rdata, 32'h0);
    chk("rst_done", {31'd0, bus.mem_done}, 32'd0);
    chk("rst_busy", {31'd0, bus.mem_busy}, 32'd0);
    chk("rst_err", {31'd0, bus.mem_err}, 32'd0);
    clear = 1'b1;
    @(negedge clock);

    // Wait-state sweep: held reads on the 0- and 15-wait instances
    bus0.mem_read = 1'b1;  bus15.mem_read = 1'b1;
    f0 = -1; s0 = -1; f15 = -1; s15 = -1;
    for (int j = 0; j < 50; j++) begin
      @(negedge clock);
      if (bus0.mem_done)  begin if (f0 < 0) f0 = j;   else if (s0 < 0) s0 = j;   end
      if (bus15.mem_done) begin if (f15 < 0) f15 = j; else if (s15 < 0) s15 = j; end
    end
    bus0.mem_read = 1'b0;  bus15.mem_read = 1'b0;
    chk("ws0_first", 32'(f0), 32'd1);
    chk("ws0_period", 32'(s0 - f0), 32'd3);
    chk("ws15_first", 32'(f15), 32'd16);
    chk("ws15_period", 32'(s15 - f15), 32'd18);

    // Table vectors
    for (int i = 0; i < 12; i++) begin
      run_chk($sformatf("tbl%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b0,
              tbl[i].exp_err, tbl[i].exp_rdata);
    end

    // Busy ignore: read 5, then switch to a write of addr 7 while busy
    run_chk("busy_ign", 1'b1, 1'b0, 32'd5, 32'h0, 1'b1, 1'b0, 32'h1234_5678);
    ndone = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clock);
      if (bus.mem_done) ndone++;
    end
    chk("busy_ign_extra_done", 32'(ndone), 32'd0);
    run_chk("busy_ign_addr7", 1'b1, 1'b0, 32'd7, 32'h0, 1'b0, 1'b0, 32'h7777_7777);

    // Abort: write DEADBEEF to 9, reset mid-access
    @(negedge clock);
    bus.mem_write = 1'b1; bus.mem_addr = 32'd9; bus.mem_wdata = 32'hDEAD_BEEF;
    @(posedge clock);
    @(posedge clock);
    #2;
    chk("abort_busy_before", {31'd0, bus.mem_busy}, 32'd1);
    clear = 1'b0;
    #1;
    chk("abort_async_rdata", bus.mem_rdata, 32'h0);
    chk("abort_async_busy", {31'd0, bus.mem_busy}, 32'd0);
    chk("abort_async_done", {31'd0, bus.mem_done}, 32'd0);
    chk("abort_async_err", {31'd0, bus.mem_err}, 32'd0);
    ndone = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      if (bus.mem_done || bus.mem_busy) ndone++;
    end
    chk("abort_no_done_in_reset", 32'(ndone), 32'd0);
    bus.mem_write = 1'b0;
    clear = 1'b1;
    @(negedge clock);
    run_chk("abort_read9", 1'b1, 1'b0, 32'd9, 32'h0, 1'b0, 1'b0, 32'h0000_0011);

    // Random traffic against the behavioural model
    ref_rdata = 32'h0000_0011;
    for (int a = 0; a < 16; a++) begin
      logic [31:0] d;
      d = $urandom;
      ref_mem[a] = d;
      run_chk($sformatf("init%0d", a), 1'b0, 1'b1, 32'(a), d, 1'b0, 1'b0, ref_rdata);
    end
    for (int n = 0; n < 150; n++) begin
      int opsel, asel;
      logic rd, wr, ee;
      logic [31:0] a, d;
      opsel = $urandom_range(0, 9);
      rd = (opsel <= 5);
      wr = (opsel == 0) || (opsel >= 6);
      asel = $urandom_range(0, 9);
      if (asel == 0)      a = 32'd512 + 32'($urandom_range(0, 1000));
      else if (asel == 1) a = 32'($urandom_range(0, 15)) | (32'h1 << $urandom_range(9, 31));
      else                a = 32'($urandom_range(0, 15));
      d = $urandom;
      ee = (rd && wr) || (a >= 32'(DEPTH));
      if (!ee) begin
        if (wr) ref_mem[int'(a)] = d;
        if (rd) ref_rdata = ref_mem[int'(a)];
      end
      run_chk($sformatf("rnd%0d", n), rd, wr, a, d, 1'b0, ee, ref_rdata);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
